// File: rtl/spike_collector.sv
// Collects adder results: potential register file, per-timestep spike vector and spike event FIFO.
// Optional SPIKE_BACKPRESSURE_EN: stall input when the FIFO is full instead of dropping events.
module spike_collector #(
  parameter int unsigned NUM_NEURONS = 10,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TS_WIDTH    = 16
) (
  input  logic                          CLK_Collector,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    in_neuron_id,
  input  logic [31:0]                   in_potential,
  input  logic                          in_spike,
  input  logic [3:0]                    rd_neuron_id,
  output logic [31:0]                   rd_potential,
  input  logic                          timestep_end,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [3:0]                    ev_neuron_id,
  output logic [TS_WIDTH-1:0]           ev_timestep,
  output logic [NUM_NEURONS-1:0]        spike_vector,
  output logic [TS_WIDTH-1:0]           ts_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          ts_done
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e                 state_q, state_d;

  logic [31:0]            mem_q [NUM_NEURONS];
  logic [31:0]            rd_potential_q, rd_potential_d;
  logic [NUM_NEURONS-1:0] cur_spikes_q, cur_spikes_d;
  logic [NUM_NEURONS-1:0] spike_vector_q, spike_vector_d;
  logic [TS_WIDTH-1:0]    ts_count_q, ts_count_d;
  logic                   overflow_q, overflow_d;

  logic [3:0]             fifo_id_q [FIFO_DEPTH];
  logic [TS_WIDTH-1:0]    fifo_ts_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic                   fifo_empty, fifo_full;
  logic                   accept, id_ok, rd_id_ok;
  logic                   spike_acc, push, pop, drop, ts_end_run;
  logic [NUM_NEURONS-1:0] spike_bit;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign id_ok      = (32'(in_neuron_id) < NUM_NEURONS);
  assign rd_id_ok   = (32'(rd_neuron_id) < NUM_NEURONS);

`ifdef SPIKE_BACKPRESSURE_EN
  assign in_ready = (state_q == RUN) && !fifo_full;
`else
  assign in_ready = (state_q == RUN);
`endif

  assign accept     = in_valid && in_ready;
  assign spike_acc  = accept && id_ok && in_spike;
  assign pop        = !fifo_empty && ev_ready;
  assign ts_end_run = timestep_end && (state_q == RUN);

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push = spike_acc && (!fifo_full || pop);

`ifdef SPIKE_BACKPRESSURE_EN
  assign drop = 1'b0;
`else
  assign drop = spike_acc && fifo_full && !pop;
`endif

  always_comb begin
    state_d = state_q;
    ts_done = 1'b0;
    case (state_q)
      RUN: begin
        if (timestep_end) state_d = FLUSH;
      end
      FLUSH: begin
        if (fifo_empty) begin
          state_d = RUN;
          ts_done = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    spike_bit = '0;
    if (spike_acc) spike_bit[in_neuron_id] = 1'b1;
  end

  always_comb begin
    cur_spikes_d   = cur_spikes_q | spike_bit;
    spike_vector_d = spike_vector_q;
    ts_count_d     = ts_count_q;
    overflow_d     = overflow_q | drop;
    // The boundary snapshot includes a spike accepted in the same cycle.
    if (ts_end_run) begin
      spike_vector_d = cur_spikes_q | spike_bit;
      cur_spikes_d   = '0;
      ts_count_d     = ts_count_q + TS_WIDTH'(1);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  always_comb begin
    rd_potential_d = '0;
    if (rd_id_ok) rd_potential_d = mem_q[rd_neuron_id];
  end

  always_ff @(posedge CLK_Collector) begin
    if (clear) begin
      state_q        <= RUN;
      rd_potential_q <= '0;
      cur_spikes_q   <= '0;
      spike_vector_q <= '0;
      ts_count_q     <= '0;
      overflow_q     <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) mem_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      rd_potential_q <= rd_potential_d;
      cur_spikes_q   <= cur_spikes_d;
      spike_vector_q <= spike_vector_d;
      ts_count_q     <= ts_count_d;
      overflow_q     <= overflow_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      if (accept && id_ok) mem_q[in_neuron_id] <= in_potential;
    end
  end

  // Event storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge CLK_Collector) begin
    if (push && !clear) begin
      fifo_id_q[wr_ptr_q] <= in_neuron_id;
      fifo_ts_q[wr_ptr_q] <= ts_count_q;
    end
  end

  assign ev_valid     = !fifo_empty;
  assign ev_neuron_id = fifo_empty ? 4'd0 : fifo_id_q[rd_ptr_q];
  assign ev_timestep  = fifo_empty ? '0 : fifo_ts_q[rd_ptr_q];
  assign rd_potential = rd_potential_q;
  assign spike_vector = spike_vector_q;
  assign ts_count     = ts_count_q;
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;

endmodule

// File: doc/spike_collector.md
# spike_collector

Downstream stage of the per-neuron potential adders. Accepts one result per cycle (neuron ID, final potential, spike flag), writes the potential back into a per-neuron potential register file, and queues spike events into a FIFO for the router/host.

At each timestep boundary it latches the timestep's spike vector. It then drains the FIFO before signalling timestep completion, and the decay stage reads stored potentials back through a registered read port.

## Interface
Parameters:
- NUM_NEURONS, 10: neurons served; IDs 0..NUM_NEURONS-1.
- FIFO_DEPTH, 8: spike event FIFO entries; power of two, ≥2.
- TS_WIDTH, 16: timestep counter width.

Ports:
- CLK_Collector  in  1  clock, all logic on rising edge.
- clear  in  1  reset; synchronous, active-high.
- in_valid  in  1  adder result valid.
- in_ready  out  1  collector can accept a result.
- in_neuron_id  in  4  neuron index of result.
- in_potential  in  32  final potential, IEEE-754 single; stored opaque, never interpreted.
- in_spike  in  1  neuron fired.
- rd_neuron_id  in  4  potential read address.
- rd_potential  out  32  stored potential, registered.
- timestep_end  in  1  single-cycle timestep boundary pulse.
- ev_valid  out  1  spike event available.
- ev_ready  in  1  consumer pops event.
- ev_neuron_id  out  4  event neuron index.
- ev_timestep  out  TS_WIDTH  timestep the spike belongs to.
- spike_vector  out  NUM_NEURONS  spikes of last completed timestep, bit i = neuron i.
- ts_count  out  TS_WIDTH  current timestep number.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- overflow  out  1  sticky: spike event dropped.
- ts_done  out  1  one-cycle pulse when boundary flush completes.

## Operation
- FSM states are RUN and FLUSH. Reset state is RUN.
- RUN → FLUSH on timestep_end. FLUSH → RUN when the FIFO is empty, with ts_done pulsed in that cycle. timestep_end is ignored in FLUSH.
- A result is accepted on in_valid && in_ready.
- in_ready is 0 in FLUSH.
- in_ready in RUN is set per the Configuration section.
- On accept with in_neuron_id < NUM_NEURONS:
  - potential regfile[id] ← in_potential.
  - If in_spike: cur_spikes[id] ← 1 and an event {id, ts_count} is pushed.
- Accepts with in_neuron_id ≥ NUM_NEURONS are consumed with no side effects and no push.
- On timestep_end in RUN:
  - spike_vector ← cur_spikes, including any spike accepted in the same cycle.
  - cur_spikes ← 0.
  - ts_count ← ts_count+1, wrapping modulo 2^TS_WIDTH.
  - An event accepted in the same cycle is tagged with the old ts_count.
- FIFO:
  - ev_valid = !empty; ev_* show the head entry; a pop occurs on ev_valid && ev_ready.
  - Simultaneous push and pop: fifo_count is unchanged; allowed when full.
  - A pop while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Read port:
  - rd_potential ← regfile[rd_neuron_id] on every edge.
  - IDs ≥ NUM_NEURONS return 0.
  - A same-cycle write to the same ID returns the old value (read-before-write).

## Timing
- Reset values: regfile all 0, cur_spikes 0, spike_vector 0, ts_count 0, FIFO empty, ev_valid 0, ev_neuron_id 0, ev_timestep 0, fifo_count 0, overflow 0, ts_done 0, rd_potential 0. State is RUN and in_ready is 1.
- clear mid-operation: all state returns to reset values on that edge. In-flight events are discarded and the accept in that cycle is ignored.
- Accept → event visible on ev_valid: 1 cycle.
- Read latency: 1 cycle.
- timestep_end → in_ready low: next cycle.
- ts_done: the cycle after the FIFO reaches empty in FLUSH. If the FIFO is already empty, ts_done is the cycle after timestep_end.
- Sustained throughput is one result per cycle in RUN.

## Configuration
- SPIKE_BACKPRESSURE_EN defined:
  - in_ready in RUN = !full.
  - A spiking result is never dropped, and overflow stays 0.
- SPIKE_BACKPRESSURE_EN undefined:
  - in_ready in RUN = 1.
  - A spiking accept while full with no same-cycle pop still writes the potential and sets the cur_spikes bit.
  - The event itself is dropped and overflow is set until clear.

## Test plan
- Reset, then write IDs 0..9 with potentials 32'h42200000+i, no spikes. Read each → rd_potential matches one cycle later; ev_valid stays 0.
- Spikes on IDs 3 and 7 at ts_count=0, then timestep_end → spike_vector=10'b0010001000, events (3,0) and (7,0) in order, ts_count=1. ts_done pulses after ev_ready drains both events.
- Hold ev_ready=0 and feed 9 spiking results:
  - With the macro: in_ready drops after 8 and fifo_count=8.
  - Without the macro: 9th event dropped, overflow=1, cur_spikes bit for that ID still set.
- Full FIFO with ev_ready=1 and a simultaneous spiking accept → fifo_count stays 8; no overflow.
- Spiking accept coinciding with timestep_end at ts_count=5 → event tagged 5 and included in spike_vector. in_valid during FLUSH is not accepted.
- in_neuron_id=12 with spike → no write, no event. Assert clear mid-FLUSH → all outputs at reset values next cycle.
